// File: rtl/ads1115_pkg.sv
// ads1115_pkg
// Shared definitions for the ADS1115 scan sequencer:
//   - register pointer constants (conversion / config)
//   - config register field positions and fixed field values
//   - sequencer state encoding
//   - cfg_word(): builds the single-shot config word for one channel
// Optional build macro: ADS1115_OS_POLL_EN adds the POLL_OS state.
package ads1115_pkg;

  localparam logic [7:0] PTR_CONV = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  localparam int CFG_OS_BIT   = 15;
  localparam int CFG_MUX_LSB  = 12;
  localparam int CFG_PGA_LSB  = 9;
  localparam int CFG_MODE_BIT = 8;
  localparam int CFG_DR_LSB   = 5;
  localparam int CFG_COMP_LSB = 0;

  localparam logic       CFG_MODE_SINGLE = 1'b1;
  localparam logic [2:0] CFG_DR_128SPS   = 3'b100;
  localparam logic [4:0] CFG_COMP_OFF    = 5'b00011;

  localparam int TIMER_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_WR_CFG,
    ST_WAIT_CONV,
    ST_RD_CONV,
    ST_STORE
`ifdef ADS1115_OS_POLL_EN
    , ST_POLL_OS
`endif
  } state_e;

  // Single-ended MUX codes are 1'b1 followed by the channel number, and
  // setting OS starts the single-shot conversion as the word is written.
  function automatic logic [15:0] cfg_word(input logic [1:0] ch, input logic [2:0] pga);
    logic [15:0] w;
    w = '0;
    w[CFG_OS_BIT]          = 1'b1;
    w[CFG_MUX_LSB +: 3]    = {1'b1, ch};
    w[CFG_PGA_LSB +: 3]    = pga;
    w[CFG_MODE_BIT]        = CFG_MODE_SINGLE;
    w[CFG_DR_LSB +: 3]     = CFG_DR_128SPS;
    w[CFG_COMP_LSB +: 5]   = CFG_COMP_OFF;
    return w;
  endfunction

endpackage

// File: rtl/ads1115_wait_timer.sv
// ads1115_wait_timer
// Loadable down-counter. start_i loads load_i; the count then falls by one
// per cycle and sticks at zero. expired_o is high while the count is zero.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         load strobe
//   load_i          value loaded on start_i
//   expired_o       count has reached zero
module ads1115_wait_timer
  import ads1115_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] load_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ads1115_scan_sequencer.sv
// ads1115_scan_sequencer
// Round-robin scanner for ADS1115 single-ended channels AIN0-AIN3. For each
// enabled channel it writes a single-shot config word, waits for the
// conversion, reads the conversion register and strobes out the result.
// NACKed transactions are re-issued up to MAX_RETRIES times; a channel that
// still fails sets the sticky err flag and is skipped.
// Optional build macro: ADS1115_OS_POLL_EN -- instead of one long fixed wait,
// the config register is polled every POLL_INTERVAL cycles until OS=1, giving
// up after POLL_LIMIT polls.
// Ports:
//   system_clock, reset_n        clock, asynchronous active-low reset
//   enable, ch_mask, pga         scan control from the application
//   txn_*                        transaction interface to the I2C master
//   sample_valid/ch/data         result strobe, channel and signed value
//   busy, err, err_ch            status
module ads1115_scan_sequencer
  import ads1115_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR         = 7'h48,
  parameter int         CONV_WAIT_CYCLES = 400000,
  parameter int         MAX_RETRIES      = 3
`ifdef ADS1115_OS_POLL_EN
  , parameter int       POLL_INTERVAL    = 5000,
  parameter int         POLL_LIMIT       = 200
`endif
) (
  input  logic        system_clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic [2:0]  pga,
  output logic        txn_req,
  output logic        txn_rw,
  output logic [6:0]  txn_addr,
  output logic [7:0]  txn_ptr,
  output logic [15:0] txn_wdata,
  input  logic        txn_done,
  input  logic        txn_nack,
  input  logic [15:0] txn_rdata,
  output logic        sample_valid,
  output logic [1:0]  sample_ch,
  output logic [15:0] sample_data,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_ch
);

  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  // The timer is loaded on the transition into WAIT_CONV and the exit is
  // decided in the cycle it reads zero; loading N-2 makes the request for the
  // following transaction rise exactly N cycles after the cycle following the
  // config done. Wait lengths below 2 are not supported.
`ifdef ADS1115_OS_POLL_EN
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [POLL_W-1:0]  POLL_MAX  = POLL_W'(POLL_LIMIT);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(POLL_INTERVAL - 2);
`else
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(CONV_WAIT_CYCLES - 2);
`endif

  state_e              state_q, state_d;
  logic [1:0]          last_ch_q, last_ch_d;
  logic [1:0]          ch_q, ch_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                txn_req_q, txn_req_d;
  logic                txn_rw_q, txn_rw_d;
  logic [7:0]          txn_ptr_q, txn_ptr_d;
  logic [15:0]         txn_wdata_q, txn_wdata_d;
  logic                sample_valid_q, sample_valid_d;
  logic [1:0]          sample_ch_q, sample_ch_d;
  logic [15:0]         sample_data_q, sample_data_d;
  logic                err_q, err_d;
  logic [1:0]          err_ch_q, err_ch_d;
`ifdef ADS1115_OS_POLL_EN
  logic [POLL_W-1:0]   poll_q, poll_d;
`endif
  logic                timer_start;
  logic                timer_expired;

  // First enabled channel strictly after 'last', wrapping 3 -> 0.
  function automatic logic [1:0] next_ch(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] c;
    logic [1:0] res;
    logic       found;
    res   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      c = last + 2'(i);
      if (!found && mask[c]) begin
        res   = c;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  ads1115_wait_timer #(.W(TIMER_W)) u_wait_timer (
    .clk_i     (system_clock),
    .rst_ni    (reset_n),
    .start_i   (timer_start),
    .load_i    (WAIT_LOAD),
    .expired_o (timer_expired)
  );

  // Next-state logic. The transaction states share one request/retry path:
  // txn_req goes high the cycle after the state is entered (or after a NACK),
  // and falls together with the state exit once a done is accepted. Every
  // exit checks enable so a dropped enable returns to IDLE at the next exit.
  always_comb begin
    state_d        = state_q;
    last_ch_d      = last_ch_q;
    ch_d           = ch_q;
    retry_d        = retry_q;
    txn_req_d      = txn_req_q;
    txn_rw_d       = txn_rw_q;
    txn_ptr_d      = txn_ptr_q;
    txn_wdata_d    = txn_wdata_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_data_d  = sample_data_q;
    err_d          = err_q;
    err_ch_d       = err_ch_q;
`ifdef ADS1115_OS_POLL_EN
    poll_d         = poll_q;
`endif
    timer_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (ch_mask != 4'b0000)) begin
          state_d = ST_PICK;
        end
      end

      ST_PICK: begin
        if (!enable || (ch_mask == 4'b0000)) begin
          state_d = ST_IDLE;
        end else begin
          ch_d        = next_ch(last_ch_q, ch_mask);
          last_ch_d   = ch_d;
          txn_rw_d    = 1'b0;
          txn_ptr_d   = PTR_CFG;
          txn_wdata_d = cfg_word(ch_d, pga);
          retry_d     = '0;
`ifdef ADS1115_OS_POLL_EN
          poll_d      = '0;
`endif
          state_d     = ST_WR_CFG;
        end
      end

`ifdef ADS1115_OS_POLL_EN
      ST_WR_CFG, ST_RD_CONV, ST_POLL_OS: begin
`else
      ST_WR_CFG, ST_RD_CONV: begin
`endif
        if (!txn_req_q) begin
          txn_req_d = 1'b1;
        end else if (txn_done) begin
          txn_req_d = 1'b0;
          if (txn_nack) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + RETRY_W'(1);
            end else begin
              retry_d  = '0;
              err_d    = 1'b1;
              err_ch_d = ch_q;
              state_d  = enable ? ST_PICK : ST_IDLE;
            end
          end else begin
            retry_d = '0;
            case (state_q)
              ST_WR_CFG: begin
                if (!enable) begin
                  state_d = ST_IDLE;
                end else begin
                  timer_start = 1'b1;
                  state_d     = ST_WAIT_CONV;
                end
              end
              ST_RD_CONV: begin
                if (!enable) begin
                  state_d = ST_IDLE;
                end else begin
                  sample_valid_d = 1'b1;
                  sample_ch_d    = ch_q;
                  sample_data_d  = txn_rdata;
                  state_d        = ST_STORE;
                end
              end
`ifdef ADS1115_OS_POLL_EN
              ST_POLL_OS: begin
                if (txn_rdata[CFG_OS_BIT]) begin
                  if (!enable) begin
                    state_d = ST_IDLE;
                  end else begin
                    txn_rw_d  = 1'b1;
                    txn_ptr_d = PTR_CONV;
                    state_d   = ST_RD_CONV;
                  end
                end else begin
                  poll_d = poll_q + POLL_W'(1);
                  if (poll_d == POLL_MAX) begin
                    err_d    = 1'b1;
                    err_ch_d = ch_q;
                    state_d  = enable ? ST_PICK : ST_IDLE;
                  end else if (!enable) begin
                    state_d = ST_IDLE;
                  end else begin
                    timer_start = 1'b1;
                    state_d     = ST_WAIT_CONV;
                  end
                end
              end
`endif
              default: begin
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      end

      ST_WAIT_CONV: begin
        if (timer_expired) begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else begin
            txn_rw_d = 1'b1;
`ifdef ADS1115_OS_POLL_EN
            txn_ptr_d = PTR_CFG;
            state_d   = ST_POLL_OS;
`else
            txn_ptr_d = PTR_CONV;
            state_d   = ST_RD_CONV;
`endif
          end
        end
      end

      ST_STORE: begin
        state_d = enable ? ST_PICK : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops txn_req immediately.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      last_ch_q      <= 2'd3;
      ch_q           <= 2'd0;
      retry_q        <= '0;
      txn_req_q      <= 1'b0;
      txn_rw_q       <= 1'b0;
      txn_ptr_q      <= 8'h00;
      txn_wdata_q    <= 16'h0000;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= 2'd0;
      sample_data_q  <= 16'h0000;
      err_q          <= 1'b0;
      err_ch_q       <= 2'd0;
`ifdef ADS1115_OS_POLL_EN
      poll_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      last_ch_q      <= last_ch_d;
      ch_q           <= ch_d;
      retry_q        <= retry_d;
      txn_req_q      <= txn_req_d;
      txn_rw_q       <= txn_rw_d;
      txn_ptr_q      <= txn_ptr_d;
      txn_wdata_q    <= txn_wdata_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_data_q  <= sample_data_d;
      err_q          <= err_d;
      err_ch_q       <= err_ch_d;
`ifdef ADS1115_OS_POLL_EN
      poll_q         <= poll_d;
`endif
    end
  end

  assign txn_req      = txn_req_q;
  assign txn_rw       = txn_rw_q;
  assign txn_addr     = I2C_ADDR;
  assign txn_ptr      = txn_ptr_q;
  assign txn_wdata    = txn_wdata_q;
  assign sample_valid = sample_valid_q;
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign err_ch       = err_ch_q;

endmodule

// File: tb/tb_ads1115_scan_sequencer.sv
// tb_ads1115_scan_sequencer
// Directed bench for ads1115_scan_sequencer with a behavioural transaction
// master/slave model that logs every transaction and can be told to NACK
// config writes, NACK everything for channel 1, or report OS=0 on polls.
// Build with ADS1115_OS_POLL_EN defined to also cover the polling variant.
module tb_ads1115_scan_sequencer;

  localparam int CONV_N    = 20;
`ifdef ADS1115_OS_POLL_EN
  localparam int WAIT_N    = 10;
`else
  localparam int WAIT_N    = CONV_N;
`endif
  localparam int MODEL_LAT = 2;

  logic        system_clock;
  logic        reset_n;
  logic        enable;
  logic [3:0]  ch_mask;
  logic [2:0]  pga;
  logic        txn_req;
  logic        txn_rw;
  logic [6:0]  txn_addr;
  logic [7:0]  txn_ptr;
  logic [15:0] txn_wdata;
  logic        txn_done;
  logic        txn_nack;
  logic [15:0] txn_rdata;
  logic        sample_valid;
  logic [1:0]  sample_ch;
  logic [15:0] sample_data;
  logic        busy;
  logic        err;
  logic [1:0]  err_ch;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state
  int          latCnt = 0;
  logic        prevReq = 1'b0;
  logic [1:0]  curCh = 2'd0;
  logic [15:0] wrLog [0:255];
  int nWr = 0, nWrAck = 0, nRdConv = 0, nRdPoll = 0;
  int addrErr = 0, ptrErr = 0;
  int cfgNacksGiven = 0, osZeroGiven = 0;
  int firstWrDone = -1, firstRdRise = -1, lastWrDone = -1;

  // Bench controls for the model
  int   cfgNackBudget = 0;
  int   osZeroBudget  = 0;
  logic failCh1       = 1'b0;

  // Sample monitor
  logic [1:0]  sampChQ [$];
  logic [15:0] sampDataQ [$];

  ads1115_scan_sequencer #(
    .I2C_ADDR         (7'h48),
    .CONV_WAIT_CYCLES (CONV_N),
    .MAX_RETRIES      (3)
`ifdef ADS1115_OS_POLL_EN
    , .POLL_INTERVAL  (10),
    .POLL_LIMIT       (20)
`endif
  ) dut (
    .system_clock (system_clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .pga          (pga),
    .txn_req      (txn_req),
    .txn_rw       (txn_rw),
    .txn_addr     (txn_addr),
    .txn_ptr      (txn_ptr),
    .txn_wdata    (txn_wdata),
    .txn_done     (txn_done),
    .txn_nack     (txn_nack),
    .txn_rdata    (txn_rdata),
    .sample_valid (sample_valid),
    .sample_ch    (sample_ch),
    .sample_data  (sample_data),
    .busy         (busy),
    .err          (err),
    .err_ch       (err_ch)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  always @(posedge system_clock) cyc++;

  function automatic logic [15:0] chData(input logic [1:0] ch);
    case (ch)
      2'd0:    return 16'h7FF0;
      2'd1:    return 16'h1234;
      2'd2:    return 16'h8010;
      default: return 16'hABCD;
    endcase
  endfunction

  // Transaction master/slave model: answers each request MODEL_LAT+1
  // negedges after it is first seen, with a one-cycle done pulse.
  always @(negedge system_clock) begin
    if (!reset_n) begin
      txn_done = 1'b0;
      txn_nack = 1'b0;
      latCnt   = 0;
      prevReq  = 1'b0;
    end else begin
      if (txn_req && !prevReq && txn_rw && (txn_ptr == 8'h00) && (firstRdRise < 0))
        firstRdRise = cyc;
      prevReq = txn_req;
      if (txn_done) begin
        txn_done = 1'b0;
        txn_nack = 1'b0;
      end else if (txn_req) begin
        if (latCnt < MODEL_LAT) begin
          latCnt++;
        end else begin
          latCnt = 0;
          if (txn_addr !== 7'h48) addrErr++;
          txn_nack = 1'b0;
          if (!txn_rw) begin
            wrLog[nWr % 256] = txn_wdata;
            nWr++;
            if (txn_ptr !== 8'h01) ptrErr++;
            if (cfgNacksGiven < cfgNackBudget) begin
              txn_nack = 1'b1;
              cfgNacksGiven++;
            end else if (failCh1 && (txn_wdata[13:12] == 2'd1)) begin
              txn_nack = 1'b1;
            end
            if (!txn_nack) begin
              curCh      = txn_wdata[13:12];
              nWrAck++;
              lastWrDone = cyc;
              if (firstWrDone < 0) firstWrDone = cyc;
            end
          end else if (txn_ptr == 8'h01) begin
            nRdPoll++;
            if (osZeroGiven < osZeroBudget) begin
              txn_rdata = 16'h0583;
              osZeroGiven++;
            end else begin
              txn_rdata = 16'h8583;
            end
          end else begin
            nRdConv++;
            txn_rdata = chData(curCh);
          end
          txn_done = 1'b1;
        end
      end else begin
        latCnt = 0;
      end
    end
  end

  always @(negedge system_clock) begin
    if (reset_n && sample_valid) begin
      sampChQ.push_back(sample_ch);
      sampDataQ.push_back(sample_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] mask, input logic [2:0] p);
    enable  = en;
    ch_mask = mask;
    pga     = p;
  endtask

  task automatic tick();
    @(negedge system_clock);
    #1;
  endtask

  task automatic waitSamples(input int target, input int budget, input string tag);
    int k = 0;
    while ((sampChQ.size() < target) && (k < budget)) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(sampChQ.size() >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int k = 0;
    while (busy && (k < budget)) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  task automatic waitWrAck(input int target, input int budget, input string tag);
    int k = 0;
    while ((nWrAck < target) && (k < budget)) begin
      tick();
      k++;
    end
    checkOutput(tag, 32'(nWrAck >= target), 32'd1);
  endtask

  initial begin
    int base, sBase, rBase, pBase, aBase, k;

    reset_n = 1'b0;
    applyStimulus(1'b0, 4'b0000, 3'b000);
    repeat (3) tick();

    // Reset values
    checkOutput("rst_txn_req", 32'(txn_req), 32'd0);
    checkOutput("rst_txn_rw", 32'(txn_rw), 32'd0);
    checkOutput("rst_txn_ptr", 32'(txn_ptr), 32'h00);
    checkOutput("rst_txn_wdata", 32'(txn_wdata), 32'h0000);
    checkOutput("rst_txn_addr", 32'(txn_addr), 32'h48);
    checkOutput("rst_sample_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_sample_ch", 32'(sample_ch), 32'd0);
    checkOutput("rst_sample_data", 32'(sample_data), 32'h0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_ch", 32'(err_ch), 32'd0);

    reset_n = 1'b1;
    tick();

    // Empty mask keeps the block idle
    applyStimulus(1'b1, 4'b0000, 3'b010);
    repeat (6) tick();
    checkOutput("mask0_busy", 32'(busy), 32'd0);
    checkOutput("mask0_req", 32'(txn_req), 32'd0);

    // Round robin over channels 0 and 2
    $display("[TB] round robin ch_mask=0101");
    base = nWr;
    applyStimulus(1'b1, 4'b0101, 3'b010);
    waitSamples(4, 600, "rr_samples_timeout");
    applyStimulus(1'b0, 4'b0101, 3'b010);
    waitIdle(300, "rr_idle_timeout");
    checkOutput("rr_wr0", 32'(wrLog[base]), 32'hC583);
    checkOutput("rr_wr1", 32'(wrLog[base + 1]), 32'hE583);
    checkOutput("rr_wr2", 32'(wrLog[base + 2]), 32'hC583);
    checkOutput("rr_wr3", 32'(wrLog[base + 3]), 32'hE583);
    checkOutput("rr_s0_ch", 32'(sampChQ[0]), 32'd0);
    checkOutput("rr_s0_data", 32'(sampDataQ[0]), 32'h7FF0);
    checkOutput("rr_s1_ch", 32'(sampChQ[1]), 32'd2);
    checkOutput("rr_s1_data", 32'(sampDataQ[1]), 32'h8010);
    checkOutput("rr_s2_ch", 32'(sampChQ[2]), 32'd0);
    checkOutput("rr_s3_data", 32'(sampDataQ[3]), 32'h8010);
`ifndef ADS1115_OS_POLL_EN
    checkOutput("conv_wait_cycles", 32'(firstRdRise - firstWrDone), 32'(CONV_N + 1));
`endif

    // Config write NACKed twice, then ACKed
    $display("[TB] config write nack x2");
    base  = nWr;
    sBase = sampChQ.size();
    rBase = nRdConv;
    cfgNackBudget = cfgNacksGiven + 2;
    applyStimulus(1'b1, 4'b0001, 3'b010);
    waitSamples(sBase + 1, 400, "nack2_sample_timeout");
    applyStimulus(1'b0, 4'b0001, 3'b010);
    waitIdle(200, "nack2_idle_timeout");
    checkOutput("nack2_writes", 32'(nWr - base), 32'd3);
    checkOutput("nack2_wr_first", 32'(wrLog[base]), 32'hC583);
    checkOutput("nack2_wr_last", 32'(wrLog[base + 2]), 32'hC583);
    checkOutput("nack2_reads", 32'(nRdConv - rBase), 32'd1);
    checkOutput("nack2_samples", 32'(sampChQ.size() - sBase), 32'd1);
    checkOutput("nack2_err", 32'(err), 32'd0);

    // Channel 1 always NACKs
    $display("[TB] channel 1 persistent nack");
    base  = nWr;
    sBase = sampChQ.size();
    failCh1 = 1'b1;
    applyStimulus(1'b1, 4'b0011, 3'b010);
    k = 0;
    while (!err && (k < 300)) begin
      tick();
      k++;
    end
    checkOutput("ch1_err", 32'(err), 32'd1);
    checkOutput("ch1_err_ch", 32'(err_ch), 32'd1);
    checkOutput("ch1_attempts", 32'(nWr - base), 32'd4);
    checkOutput("ch1_wdata", 32'(wrLog[base + 3]), 32'hD583);
    waitSamples(sBase + 1, 400, "ch1_next_sample_timeout");
    checkOutput("ch1_next_ch", 32'(sampChQ[sBase]), 32'd0);
    checkOutput("ch1_next_data", 32'(sampDataQ[sBase]), 32'h7FF0);
    applyStimulus(1'b0, 4'b0011, 3'b010);
    waitIdle(400, "ch1_idle_timeout");
    failCh1 = 1'b0;

    // enable dropped while waiting for the conversion
    $display("[TB] enable drop in wait");
    sBase = sampChQ.size();
    rBase = nRdConv;
    pBase = nRdPoll;
    aBase = nWrAck;
    applyStimulus(1'b1, 4'b0001, 3'b010);
    waitWrAck(aBase + 1, 100, "drop_wr_timeout");
    repeat (3) tick();
    applyStimulus(1'b0, 4'b0001, 3'b010);
    k = 0;
    while (busy && (k < 200)) begin
      tick();
      k++;
    end
    checkOutput("drop_busy_timing", 32'(cyc - lastWrDone), 32'(WAIT_N));
    repeat (10) tick();
    checkOutput("drop_conv_reads", 32'(nRdConv - rBase), 32'd0);
    checkOutput("drop_poll_reads", 32'(nRdPoll - pBase), 32'd0);
    checkOutput("drop_samples", 32'(sampChQ.size() - sBase), 32'd0);
    checkOutput("drop_busy", 32'(busy), 32'd0);

    // Reset while a request is outstanding
    $display("[TB] reset mid transaction");
    applyStimulus(1'b1, 4'b0101, 3'b010);
    k = 0;
    while (!(txn_req && !txn_done) && (k < 50)) begin
      tick();
      k++;
    end
    checkOutput("mid_req_seen", 32'(txn_req), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(txn_req), 32'd0);
    checkOutput("mid_rst_wdata", 32'(txn_wdata), 32'h0000);
    checkOutput("mid_rst_ptr", 32'(txn_ptr), 32'h00);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    checkOutput("mid_rst_err_ch", 32'(err_ch), 32'd0);
    checkOutput("mid_rst_sample_data", 32'(sample_data), 32'h0000);
    checkOutput("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
    tick();
    base = nWr;
    aBase = nWrAck;
    tick();
    reset_n = 1'b1;
    waitWrAck(aBase + 1, 100, "mid_first_wr_timeout");
    checkOutput("mid_first_wr", 32'(wrLog[base]), 32'hC583);
    applyStimulus(1'b0, 4'b0101, 3'b010);
    waitIdle(200, "mid_idle_timeout");

`ifdef ADS1115_OS_POLL_EN
    // OS bit reads 0 three times before the conversion completes
    $display("[TB] os polling");
    sBase = sampChQ.size();
    rBase = nRdConv;
    pBase = nRdPoll;
    osZeroBudget = osZeroGiven + 3;
    applyStimulus(1'b1, 4'b0001, 3'b010);
    waitSamples(sBase + 1, 800, "poll_sample_timeout");
    applyStimulus(1'b0, 4'b0001, 3'b010);
    waitIdle(300, "poll_idle_timeout");
    checkOutput("poll_reads", 32'(nRdPoll - pBase), 32'd4);
    checkOutput("poll_conv_reads", 32'(nRdConv - rBase), 32'd1);
    checkOutput("poll_data", 32'(sampDataQ[sBase]), 32'h7FF0);
`endif

    checkOutput("addr_always_48", 32'(addrErr), 32'd0);
    checkOutput("write_ptr_cfg", 32'(ptrErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
